fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The module SHALL have port imem_req, output, 1 bit: instruction memory request.
REQ-005 The module SHALL have port imem_addr, output, 32 bits: fetch address, always equal to the internal pc.
REQ-006 The module SHALL have port imem_gnt, input, 1 bit: request accepted this cycle.
REQ-007 The module SHALL have port imem_rvalid, input, 1 bit: read data valid.
REQ-008 The module SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-009 The module SHALL have port redirect_valid, input, 1 bit: branch/jump redirect strobe.
REQ-010 The module SHALL have port redirect_pc, input, 32 bits: redirect target.
REQ-011 The module SHALL have port stall, input, 1 bit: decode/imm_gen stage not ready.
REQ-012 The module SHALL have port instr_valid, output, 1 bit: instr holds a valid instruction.
REQ-013 The module SHALL have port instr, output, 32 bits: registered instruction word fed to the decode/immediate stage.
REQ-014 The module SHALL have port instr_pc, output, 32 bits: address instr was fetched from.
REQ-015 The module SHALL have port instr_illegal, output, 1 bit: illegal-encoding flag for instr.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT, VALID, with at most one outstanding memory request.
REQ-017 IDLE: all outputs inactive; the FSM SHALL move to REQ unconditionally on the next clock; imem_rvalid SHALL be ignored.
REQ-018 REQ: imem_req=1; on imem_gnt=1 the FSM SHALL move to WAIT, otherwise it holds REQ with imem_addr stable.
REQ-019 WAIT: imem_req=0; on imem_rvalid=1 with no pending discard, instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, and the FSM SHALL move to VALID.
REQ-020 VALID: instr_valid=1; instr and instr_pc SHALL stay stable while stall=1; when stall=0 the instruction is consumed and the FSM SHALL move to REQ, so instr_valid drops the next cycle.
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 redirect_valid SHALL take priority over every other event: pc<=redirect_pc with bits [1:0] forced to 2'b00.
REQ-023 Redirect in IDLE or in REQ without imem_gnt: next state SHALL be REQ with the new pc.
REQ-024 Redirect in REQ with imem_gnt in the same cycle, or in WAIT without imem_rvalid: the FSM SHALL set a discard flag and go to (or stay in) WAIT, drop the next imem_rvalid data, then go to REQ.
REQ-025 Redirect in WAIT coinciding with imem_rvalid: the data SHALL be dropped and the FSM SHALL go to REQ.
REQ-026 Redirect in VALID, regardless of stall: instr_valid SHALL deassert the next cycle and the FSM SHALL go to REQ.
REQ-027 imem_gnt or imem_rvalid outside REQ/WAIT respectively SHALL be ignored.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, pc=RESET_PC, discard=0, imem_req=0, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0, instr_illegal=0.
REQ-029 Reset asserted mid-transaction SHALL abandon the request; a late imem_rvalid after reset release SHALL be ignored.

Configuration
REQ-030 With macro FETCH_ILLEGAL_CHECK_EN defined, instr_illegal SHALL be registered with instr and set when imem_rdata[1:0]!=2'b11 or imem_rdata==32'h0000_0000.
REQ-031 Without FETCH_ILLEGAL_CHECK_EN, instr_illegal SHALL be constant 0 and no check logic SHALL be instantiated.

Verification
REQ-032 Reset release, gnt and rvalid each one cycle late, rdata=32'h0050_0093 -> imem_addr=0, then instr_valid=1, instr=32'h0050_0093, instr_pc=0, next imem_addr=4.
REQ-033 stall=1 for 3 cycles in VALID -> instr, instr_pc and instr_valid held constant, no imem_req; stall=0 -> REQ the next cycle.
REQ-034 redirect_valid with redirect_pc=32'h0000_0103 during WAIT, then rvalid with rdata=32'hDEAD_BEEF -> data dropped, instr_valid stays 0, next imem_addr=32'h0000_0100.
REQ-035 pc=32'hFFFF_FFFC fetch completes -> instr_pc=32'hFFFF_FFFC, next imem_addr=32'h0000_0000.
REQ-036 With FETCH_ILLEGAL_CHECK_EN, rdata=32'h0000_0001 -> instr_illegal=1; rdata=32'h0000_0013 -> instr_illegal=0; without the macro -> 0 in both cases.
REQ-037 rst_n asserted in WAIT, imem_rvalid pulsed one cycle after release -> instr_valid=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM with redirect and stall handling.
// Optional macro FETCH_ILLEGAL_CHECK_EN enables the registered illegal-encoding flag.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_illegal
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_pc_q;
   logic        discard_q, discard_d, load;
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      discard_d = discard_q;
      load      = 1'b0;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: if (imem_gnt) begin
            state_d   = WAIT;
            discard_d = redirect_valid;
         end
         WAIT: if (imem_rvalid) begin
            load      = !discard_q && !redirect_valid;
            state_d   = load ? VALID : REQ;
            discard_d = 1'b0;
         end else if (redirect_valid) discard_d = 1'b1;
         VALID: if (!stall) state_d = REQ;
         default: state_d = IDLE;
      endcase
      if (load) pc_d = pc_q + 32'd4;
      // redirect overrides the pc in every state and cancels a held instruction
      if (redirect_valid) begin
         pc_d = {redirect_pc[31:2], 2'b00};
         if (state_q == VALID) state_d = REQ;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         discard_q  <= 1'b0;
         instr_q    <= 32'h0000_0013;
         instr_pc_q <= 32'h0000_0000;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         discard_q <= discard_d;
         if (load) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
         end
      end
   end
`ifdef FETCH_ILLEGAL_CHECK_EN
   logic illegal_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) illegal_q <= 1'b0;
      else if (load) illegal_q <= (imem_rdata[1:0] != 2'b11) || (imem_rdata == 32'h0000_0000);
   end
   assign instr_illegal = illegal_q;
`else
   assign instr_illegal = 1'b0;
`endif
   assign imem_req    = state_q == REQ;
   assign imem_addr   = pc_q;
   assign instr_valid = state_q == VALID;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
endmodule
